// File: rtl/key_event_pkg.sv
// Shared key-input definitions: FSM state encodings and 50 MHz cycle-count defaults,
// common to the debouncer and the button event decoder.
package key_event_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS  = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HELD   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRESS  = ST_PRESS,
    WAIT2  = ST_WAIT2,
    PRESS2 = ST_PRESS2,
    HELD   = ST_HELD
  } state_e;

  localparam int CLK_HZ         = 50_000_000;
  localparam int LONG_CYC_DEF   = CLK_HZ;            // 1 s
  localparam int REPEAT_CYC_DEF = CLK_HZ / 5;        // 200 ms
  localparam int DBL_CYC_DEF    = (CLK_HZ / 10) * 3; // 300 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/event_timer.sv
// Up-counter with clear/increment controls and a terminal-count compare against
// a term value chosen by the controlling FSM.
module event_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [TW-1:0] term,
  output logic          tc
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign tc = (count == term);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short, double, long and auto-repeat
// single-cycle event ticks.
module button_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF,
  parameter int DBL_CYC    = DBL_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic db_level,
  output logic short_tick,
  output logic double_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic busy
);

  localparam int TW = $clog2(max3(LONG_CYC, REPEAT_CYC, DBL_CYC) + 1);
  // Disabled features get a harmless 0 terminal; their states never consult it.
  localparam logic [TW-1:0] LONG_T = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] REP_T  = TW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam logic [TW-1:0] DBL_T  = TW'((DBL_CYC > 0) ? DBL_CYC - 1 : 0);

  state_e        state, state_n;
  logic          lvl_q, rise, fall;
  logic          t_clr, t_inc, tc;
  logic [TW-1:0] term;
  logic          short_n, double_n, long_n, repeat_n;

  assign rise = db_level & ~lvl_q;
  assign fall = ~db_level & lvl_q;
  assign busy = (state != IDLE);

  event_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (t_clr),
    .inc   (t_inc),
    .term  (term),
    .tc    (tc)
  );

  always_comb begin
    state_n  = state;
    t_clr    = 1'b0;
    t_inc    = 1'b0;
    term     = '0;
    short_n  = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
    repeat_n = 1'b0;
    case (state)
      IDLE: begin
        t_clr = 1'b1;
        if (rise) state_n = PRESS;
      end
      PRESS: begin
        term = LONG_T;
        // The long condition needs the level high, so a coincident fall wins.
        if (db_level && tc) begin
          long_n  = 1'b1;
          state_n = HELD;
          t_clr   = 1'b1;
        end else if (fall) begin
          t_clr = 1'b1;
          if (DBL_CYC == 0) begin
            short_n = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT2;
          end
        end else begin
          t_inc = 1'b1;
        end
      end
      WAIT2: begin
        term = DBL_T;
        if (rise) begin
          double_n = 1'b1;
          state_n  = PRESS2;
          t_clr    = 1'b1;
        end else if (tc) begin
          short_n = 1'b1;
          state_n = IDLE;
          t_clr   = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      PRESS2: begin
        t_clr = 1'b1;
        if (fall) state_n = IDLE;
      end
      HELD: begin
        term = REP_T;
        if (fall) begin
          state_n = IDLE;
          t_clr   = 1'b1;
        end else if (REPEAT_CYC != 0) begin
          if (tc) begin
            repeat_n = 1'b1;
            t_clr    = 1'b1;
          end else begin
            t_inc = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        t_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lvl_q       <= 1'b0;
      short_tick  <= 1'b0;
      double_tick <= 1'b0;
      long_tick   <= 1'b0;
      repeat_tick <= 1'b0;
    end else begin
      state       <= state_n;
      lvl_q       <= db_level;
      short_tick  <= short_n;
      double_tick <= double_n;
      long_tick   <= long_n;
      repeat_tick <= repeat_n;
    end
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, active-high button level produced by the team's debouncer and classifies each press into events: short press, double press, long press, and auto-repeat while held.
- Sits between the debouncer and the application control logic, such as SVGA mode selection and menu stepping.
- All event outputs are registered single-cycle ticks in the clk domain.

Parameters:
- LONG_CYC, 50_000_000, cycles a press must last to count as long (1 s at 50 MHz); must be >= 2.
- REPEAT_CYC, 10_000_000, cycles between auto-repeat ticks after a long press; 0 disables repeat.
- DBL_CYC, 15_000_000, window in cycles after a short release in which a second press counts as a double press; 0 disables double detection.
- TW, derived localparam, timer width = clog2(max(LONG_CYC, REPEAT_CYC, DBL_CYC) + 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- db_level  in  1  debounced button level, already synchronous to clk
- short_tick  out  1  one-cycle pulse: single short press completed
- double_tick  out  1  one-cycle pulse: second press started inside the double window
- long_tick  out  1  one-cycle pulse: press has lasted LONG_CYC cycles
- repeat_tick  out  1  one-cycle pulse: every REPEAT_CYC cycles while held after long_tick
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n). On reset, state=IDLE, timer=0, lvl_q=0, and all ticks and busy are 0. Reset asserted mid-operation aborts immediately and emits no events.
- Edges:
  - lvl_q is the registered copy of db_level.
  - rise = db_level & ~lvl_q; fall = ~db_level & lvl_q.
  - A button held through reset release is treated as a fresh press, i.e. a rise on the first edge.
- State, timer and ticks all update on the same clk edge. Each tick is high for exactly one cycle.
- Let t0 be the edge at which rise is first true.
- IDLE:
  - rise -> PRESS, timer=0.
- PRESS (timer increments each edge):
  - db_level high and timer==LONG_CYC-1 -> long_tick=1, HELD, timer=0. long_tick is therefore high during the cycle following edge t0+LONG_CYC.
  - fall with DBL_CYC==0 -> short_tick=1, IDLE.
  - fall with DBL_CYC!=0 -> WAIT2, timer=0.
  - If fall and the long terminal count coincide, fall wins, since the long condition requires db_level high.
- WAIT2 (timer increments):
  - rise -> double_tick=1, PRESS2.
  - else timer==DBL_CYC-1 -> short_tick=1, IDLE.
  - If rise and window expiry coincide, rise wins and gives double_tick with no short_tick.
- PRESS2:
  - No long or repeat detection.
  - fall -> IDLE with no further tick.
- HELD (timer increments; only when REPEAT_CYC!=0):
  - timer==REPEAT_CYC-1 -> repeat_tick=1, timer=0. The first repeat comes REPEAT_CYC cycles after long_tick, then every REPEAT_CYC cycles.
  - fall -> IDLE with no tick. Fall beats a coincident repeat terminal count.
- Invalid state encodings -> IDLE.
- Timer arithmetic: unsigned TW bits. The timer never wraps, because every terminal compare resets or leaves the state first.
- At most one tick is asserted in any cycle.

Decomposition:
- Shared package key_event_pkg holds:
  - the state encodings IDLE, PRESS, WAIT2, PRESS2, HELD (3-bit localparams);
  - the default cycle-count constants for 50 MHz, so the debouncer and this block share one clock-rate definition.
- One natural sub-module, event_timer: a TW-bit counter with zero/inc controls and a terminal-compare input. It is the same control/datapath split the team uses for the debouncer timer. The FSM stays in the top.

Test Plan (LONG_CYC=8, REPEAT_CYC=4, DBL_CYC=6):
- Press held 3 cycles, then release, no second press -> exactly one short_tick, 6 cycles after the fall edge. No other ticks. busy drops in the same cycle.
- Press 3 cycles, release 2 cycles, press again 2 cycles, release -> double_tick on the second rise edge. No short_tick and no long_tick. Back in IDLE after the second fall.
- Press held 20 cycles -> long_tick 8 cycles after t0, then repeat_tick at t0+12, t0+16 and t0+20 (the last coincides with the fall, so no tick). No tick after the fall.
- Release on exactly the edge where timer==7 in PRESS -> no long_tick; enter WAIT2; short_tick 6 cycles later.
- rst_n pulsed low while in HELD with db_level still high -> all outputs 0 immediately. After release, a fresh press is detected and long_tick follows 8 cycles later.
- Rerun with REPEAT_CYC=0 and DBL_CYC=0 -> no repeat ticks while held. short_tick asserts on the fall edge itself.
